// File: rtl/ultra_sonic_echo_gen.sv
// HC-SR04-style ultrasonic sensor emulator: qualifies a host trigger pulse,
// waits a fixed burst delay, then drives an echo pulse of programmable width.
module ultra_sonic_echo_gen #(
  parameter int COUNT_WIDTH = 32,
  parameter int TRIG_MIN    = 500,
  parameter int BURST_DELAY = 10000,
  parameter int MAX_ECHO    = 1900000,
  parameter int HOLDOFF     = 500000
) (
  input  logic                   clk,
  input  logic                   reset_l,
  input  logic                   trigger,
  input  logic                   write_valid,
  input  logic [COUNT_WIDTH-1:0] write_data,
  output logic                   echo,
  output logic                   busy,
  output logic                   done_pulse,
  output logic [15:0]            short_trig_count,
  output logic [15:0]            missed_trig_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HIGH,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] TRIG_MIN_C   = COUNT_WIDTH'(TRIG_MIN);
  localparam logic [COUNT_WIDTH-1:0] BURST_LAST_C = COUNT_WIDTH'(BURST_DELAY - 1);
  localparam logic [COUNT_WIDTH-1:0] HOLD_LAST_C  = COUNT_WIDTH'(HOLDOFF - 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_ECHO_C   = COUNT_WIDTH'(MAX_ECHO);
  localparam logic [COUNT_WIDTH-1:0] ONE_C        = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] len_q;
  logic [COUNT_WIDTH-1:0] echo_len_q, echo_len_d;
  logic [15:0]            short_q, short_d;
  logic [15:0]            missed_q, missed_d;
  logic                   sync1_q, trig_s_q, trig_d_q;
  logic [1:0]             fill_q;
  logic                   armed_q, armed_d;
  logic                   echo_q, done_q, busy_q;
  logic                   rise;

  // A trigger already high when reset releases must be seen low before it can
  // count: arming waits until the synchronizer holds a real pin sample.
  assign armed_d = armed_q | (fill_q[1] & ~trig_s_q);
  assign rise    = trig_s_q & ~trig_d_q & armed_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      sync1_q    <= 1'b0;
      trig_s_q   <= 1'b0;
      trig_d_q   <= 1'b0;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      echo_len_q <= '0;
      short_q    <= '0;
      missed_q   <= '0;
      echo_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= trigger;
      trig_s_q   <= sync1_q;
      trig_d_q   <= trig_s_q;
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      echo_len_q <= echo_len_d;
      short_q    <= short_d;
      missed_q   <= missed_d;
      echo_q     <= (state_d == S_ECHO);
      done_q     <= (state_q == S_ECHO) && (state_d == S_HOLDOFF);
      busy_q     <= (state_d != S_IDLE);
      if (write_valid) len_q <= write_data;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    echo_len_d = echo_len_q;
    short_d    = short_q;
    missed_d   = missed_q;

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_TRIG_HIGH;
          cnt_d   = ONE_C;
        end
      end
      S_TRIG_HIGH: begin
        if (trig_s_q) begin
          if (cnt_q < TRIG_MIN_C) cnt_d = cnt_q + ONE_C;
        end else if (cnt_q >= TRIG_MIN_C) begin
          state_d = S_BURST;
          cnt_d   = BURST_LAST_C;
          // Width is frozen here; later writes only shape the next measurement.
          echo_len_d = ((len_q == '0) || (len_q > MAX_ECHO_C)) ? MAX_ECHO_C : len_q;
        end else begin
          state_d = S_IDLE;
          if (short_q != 16'hFFFF) short_d = short_q + 16'd1;
        end
      end
      S_BURST: begin
        if (cnt_q == '0) begin
          state_d = S_ECHO;
          cnt_d   = echo_len_q - ONE_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_ECHO: begin
        if (cnt_q == '0) begin
          state_d = S_HOLDOFF;
          cnt_d   = HOLD_LAST_C;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - ONE_C;
      end
      default: state_d = S_IDLE;
    endcase

    if (rise && (state_q inside {S_BURST, S_ECHO, S_HOLDOFF}) && (missed_q != 16'hFFFF))
      missed_d = missed_q + 16'd1;
  end

  assign echo              = echo_q;
  assign done_pulse        = done_q;
  assign busy              = busy_q;
  assign short_trig_count  = short_q;
  assign missed_trig_count = missed_q;

endmodule

// File: tb/tb_ultra_sonic_echo_gen.sv
// Self-checking bench for ultra_sonic_echo_gen: a pulse-level reference model
// predicts echo/busy/done/count traces from the trigger pulses and writes.
module tb_ultra_sonic_echo_gen;

  localparam int TMIN = 4;
  localparam int BD   = 3;
  localparam int HO   = 5;
  localparam int MAXE = 100;
  localparam int INF  = 32'h3fffffff;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        trigger = 1'b0;
  logic        write_valid = 1'b0;
  logic [31:0] write_data = '0;
  logic        echo, busy, done_pulse;
  logic [15:0] short_trig_count, missed_trig_count;

  ultra_sonic_echo_gen #(
    .COUNT_WIDTH(32),
    .TRIG_MIN   (TMIN),
    .BURST_DELAY(BD),
    .MAX_ECHO   (MAXE),
    .HOLDOFF    (HO)
  ) dut (
    .clk              (clk),
    .reset_l          (reset_l),
    .trigger          (trigger),
    .write_valid      (write_valid),
    .write_data       (write_data),
    .echo             (echo),
    .busy             (busy),
    .done_pulse       (done_pulse),
    .short_trig_count (short_trig_count),
    .missed_trig_count(missed_trig_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Pulse r = edge where the first synchronizer flop samples trigger high,
  // w = number of high samples (-1 while the pulse is still being driven).
  int pr[$];
  int pw[$];
  int wr_e[$];
  int wr_v[$];
  int short_base  = 0;
  int missed_base = 0;
  int cur_len     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int echo_len(input int latch_edge);
    int v = 0;
    foreach (wr_e[i]) if (wr_e[i] < latch_edge) v = wr_v[i];
    if (v == 0 || v > MAXE) return MAXE;
    return v;
  endfunction

  // Expected outputs right after clock edge t.
  function automatic void model(input int t, output bit e, output bit b, output bit d,
                                output int sh, output int mi);
    int idle_from = 0;
    int ns = 0;
    int nm = 0;
    e = 0; b = 0; d = 0;
    foreach (pr[k]) begin
      int r = pr[k];
      int w = pw[k];
      int e0, l, up, dn, idl;
      if (r + 1 < idle_from) begin
        if (t >= r + 2) nm++;
        continue;
      end
      if (w < 0) begin
        if (t >= r + 2) b = 1;
        idle_from = INF;
        continue;
      end
      e0 = r + w;
      if (t >= r + 2 && t < e0 + 2) b = 1;
      if (w < TMIN) begin
        if (t >= e0 + 2) ns++;
        idle_from = e0 + 2;
        continue;
      end
      l   = echo_len(e0 + 2);
      up  = e0 + 2 + BD;
      dn  = up + l;
      idl = dn + HO;
      if (t >= e0 + 2 && t < idl) b = 1;
      if (t >= up && t < dn) e = 1;
      if (t == dn) d = 1;
      idle_from = idl;
    end
    sh = (short_base + ns > 65535) ? 65535 : short_base + ns;
    mi = (missed_base + nm > 65535) ? 65535 : missed_base + nm;
  endfunction

  task automatic tick();
    bit e, b, d;
    int sh, mi;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    model(cyc, e, b, d, sh, mi);
    check("echo", echo, e);
    check("busy", busy, b);
    check("done_pulse", done_pulse, d);
    check("short_cnt", short_trig_count, sh);
    check("missed_cnt", missed_trig_count, mi);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse(input int w, input int gap);
    int k;
    trigger = 1'b1;
    pr.push_back(cyc + 1);
    pw.push_back(-1);
    k = pr.size() - 1;
    ticks(w);
    trigger = 1'b0;
    pw[k] = w;
    ticks(gap);
  endtask

  task automatic wr(input int v);
    write_valid = 1'b1;
    write_data  = v;
    wr_e.push_back(cyc + 1);
    wr_v.push_back(v);
    cur_len = v;
    tick();
    write_valid = 1'b0;
  endtask

  // Only called while the DUT is idle: history is dropped, counts re-based.
  task automatic rebase(input int sh, input int mi);
    pr.delete(); pw.delete(); wr_e.delete(); wr_v.delete();
    wr_e.push_back(cyc);
    wr_v.push_back(cur_len);
    short_base  = sh;
    missed_base = mi;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    repeat (2) @(negedge clk);
    pr.delete(); pw.delete(); wr_e.delete(); wr_v.delete();
    short_base = 0; missed_base = 0; cur_len = 0;
    reset_l = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_echo", echo, 0);
    check("rst_busy", busy, 0);
    ticks(3);

    // Basic qualified trigger, then short triggers and the TRIG_MIN boundary.
    wr(20);
    pulse(6, 40);
    pulse(3, 5);
    pulse(3, 5);
    pulse(4, 30);

    // Zero and oversize lengths clamp to MAX_ECHO.
    wr(0);
    pulse(5, 120);
    wr(250);
    pulse(5, 120);

    // Write on the latch edge and a trigger during BURST.
    wr(20);
    pulse(5, 0);
    ticks(2);
    wr(7);
    pulse(1, 40);
    pulse(4, 30);

    // Counter saturation via preloaded counts.
    force dut.short_q  = 16'hFFFD;
    force dut.missed_q = 16'hFFFE;
    rebase(16'hFFFD, 16'hFFFE);
    tick();
    release dut.short_q;
    release dut.missed_q;
    repeat (3) pulse(3, 3);
    pulse(4, 2);
    repeat (3) pulse(1, 2);
    pulse(1, 40);

    // Asynchronous reset in the middle of an echo, trigger held high across it.
    wr(30);
    pulse(4, 10);
    check("echo_before_rst", echo, 1);
    #2;
    reset_l = 1'b0;
    trigger = 1'b1;
    #1;
    check("async_rst_echo", echo, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done_pulse, 0);
    check("async_rst_short", short_trig_count, 0);
    check("async_rst_missed", missed_trig_count, 0);
    do_reset();
    ticks(8);
    trigger = 1'b0;
    ticks(2);

    // Back-to-back triggers exactly at the end of HOLDOFF, then one cycle early.
    wr(10);
    repeat (4) pulse(4, 19);
    pulse(4, 18);
    pulse(4, 40);
    pulse(4, 40);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) wr(int'($urandom_range(0, 120)));
      pulse(int'($urandom_range(1, 8)), int'($urandom_range(1, 50)));
    end
    ticks(120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
